dcache_ctrl: RTL

Sequencing controller for the 2-way, 16-set, 2-word-block write-back data cache. It owns no tag or data storage. It drives the cache table's single read/write port and the data-memory side of the cache-to-memory bus. It sequences miss writeback and refill, the halt-time flush of all dirty blocks, and the final hit-count store. It sits between the dcache lookup/table logic and memory control.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/dcache_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, data-cache address fields and the
// dcache controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int DTAG_W = 25;
  localparam int DIDX_W = 4;

  // Datapath address split for the 2-way, 16-set, 2-word-block dcache.
  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    FILL0,
    FILL1,
    FLUSH_CHK,
    FLUSH0,
    FLUSH1,
    CNT,
    HALTED
  } dctrl_state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// Sequencing controller for the 2-way write-back dcache: miss writeback and
// refill, halt-time flush of dirty blocks, and the final hit-count store.
// The tag/data table lives elsewhere; this block only drives its single port.
//
// Memory handshake: dREN/dWEN, daddr and dstore are decoded from state only
// and are held unchanged while dwait is high. The access completes in the
// cycle dwait is low, and the state advances on that clock edge.
module dcache_ctrl
  import cpu_types_pkg::*;
#(
  parameter word_t CNT_ADDR = 32'h3100
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               req,
  input  logic               hit,
  input  word_t              addr,
  input  logic               victim_way,
  input  logic               halt,
  output logic [DIDX_W-1:0]  tbl_set,
  output logic               tbl_way,
  input  logic               tbl_valid,
  input  logic               tbl_dirty,
  input  logic [DTAG_W-1:0]  tbl_tag,
  input  word_t              tbl_data0,
  input  word_t              tbl_data1,
  output logic               tbl_wen,
  output logic               tbl_wofs,
  output word_t              tbl_wdata,
  output logic               tbl_fill,
  output logic               tbl_clean,
  output logic               dREN,
  output logic               dWEN,
  output word_t              daddr,
  output word_t              dstore,
  input  logic               dwait,
  input  word_t              dload,
  output logic               busy,
  output logic               flushed,
  output dctrl_state_t       dbg_state
);

  dctrl_state_t state, state_n;
  logic [4:0]   fptr, fptr_n;
  word_t        hit_cnt;
  logic         retry;
  dcachef_t     addr_f;
  logic         wofs;
  logic         unused_addr_bits;

  assign addr_f           = dcachef_t'(addr);
  assign unused_addr_bits = ^{addr_f.blkoff, addr_f.bytoff};

  // Second word of a block is handled in the *1 states.
  assign wofs = (state == WB1) | (state == FILL1) | (state == FLUSH1);

  assign busy      = (state != IDLE) | (req & ~hit) | halt;
  assign dbg_state = state;

  // State, flush pointer, hit counter and the post-refill retry marker.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      fptr    <= '0;
      hit_cnt <= '0;
      retry   <= 1'b0;
    end else begin
      state <= state_n;
      fptr  <= fptr_n;
      // The hit seen on the retry after a refill is not a real hit.
      if ((state == IDLE) && req && hit && !retry)
        hit_cnt <= hit_cnt + 32'd1;
      if ((state == FILL1) && !dwait)
        retry <= 1'b1;
      else if (state == IDLE)
        retry <= 1'b0;
    end
  end

  // Next-state decode plus Moore memory outputs and table port strobes.
  always_comb begin
    state_n   = state;
    fptr_n    = fptr;
    tbl_set   = addr_f.idx;
    tbl_way   = victim_way;
    tbl_wen   = 1'b0;
    tbl_wofs  = 1'b0;
    tbl_wdata = '0;
    tbl_fill  = 1'b0;
    tbl_clean = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    flushed   = 1'b0;
    case (state)
      IDLE: begin
        // Halt wins over a miss arriving in the same cycle.
        if (halt) begin
          state_n = FLUSH_CHK;
          fptr_n  = '0;
        end else if (req && !hit) begin
          state_n = (tbl_valid && tbl_dirty) ? WB0 : FILL0;
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {tbl_tag, addr_f.idx, wofs, 2'b00};
        dstore = wofs ? tbl_data1 : tbl_data0;
        if (!dwait)
          state_n = (state == WB0) ? WB1 : FILL0;
      end
      FILL0, FILL1: begin
        dREN     = 1'b1;
        daddr    = {addr[31:3], wofs, 2'b00};
        tbl_wofs = wofs;
        if (!dwait) begin
          tbl_wen   = 1'b1;
          tbl_wdata = dload;
          if (state == FILL1) begin
            tbl_fill = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n  = FILL1;
          end
        end
      end
      FLUSH_CHK: begin
        tbl_set = fptr[4:1];
        tbl_way = fptr[0];
        if (tbl_valid && tbl_dirty)
          state_n = FLUSH0;
        else if (fptr == 5'd31)
          state_n = CNT;
        else
          fptr_n = fptr + 5'd1;
      end
      FLUSH0, FLUSH1: begin
        tbl_set = fptr[4:1];
        tbl_way = fptr[0];
        dWEN    = 1'b1;
        daddr   = {tbl_tag, fptr[4:1], wofs, 2'b00};
        dstore  = wofs ? tbl_data1 : tbl_data0;
        if (!dwait) begin
          if (state == FLUSH0) begin
            state_n = FLUSH1;
          end else begin
            tbl_clean = 1'b1;
            if (fptr == 5'd31) begin
              state_n = CNT;
            end else begin
              fptr_n  = fptr + 5'd1;
              state_n = FLUSH_CHK;
            end
          end
        end
      end
      CNT: begin
        dWEN   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = hit_cnt;
        if (!dwait)
          state_n = HALTED;
      end
      HALTED: begin
        flushed = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
